alarm_controller: RTL and testbench

Alarm sequencer between the debounced button/switch controls and the timekeeping/display datapath. Holds a settable alarm time and routes minute/hour adjust pulses either to the running timer or to the alarm register. Selects the number shown on the display and runs an ARMED/RINGING/SNOOZE state machine that drives a blinking alarm LED. Time values use the packed-decimal unsigned encoding used across the design: `hh*10000 + mm*100 + ss`, 24-hour format.

---
 rtl/alarm_controller.sv | 195 +++++++++++++++++++
 tb/tb_alarm_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm time register, display mux and DISARMED/ARMED/RINGING/SNOOZE sequencer with blinking LED.
// Define ALARM_SNOOZE_EN to build the snooze path (dismiss while ringing re-rings SNOOZE_MINUTES later).
module alarm_controller #(
  parameter int CLK_FREQ          = 100_000_000,
  parameter int BLINK_HZ          = 2,
  parameter int RING_SECONDS      = 60,
  parameter int SNOOZE_MINUTES    = 5,
  parameter int ALARM_RST_HOURS   = 7,
  parameter int ALARM_RST_MINUTES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] time_number,
  input  logic        alarm_en,
  input  logic        set_mode,
  input  logic        adjust_minutes,
  input  logic        adjust_hours,
  input  logic        dismiss,
  output logic        timer_adjust_minutes,
  output logic        timer_adjust_hours,
  output logic [23:0] alarm_number,
  output logic [23:0] display_number,
  output logic        ringing,
  output logic        led
);

  localparam int HALF_RAW = CLK_FREQ / (2 * BLINK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int BW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int RW       = (RING_SECONDS < 1) ? 1 : $clog2(RING_SECONDS + 1);

  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_SECONDS);

  if (SNOOZE_MINUTES < 1 || SNOOZE_MINUTES > 59) begin : g_bad_snooze
    $error("alarm_controller: SNOOZE_MINUTES must be 1..59");
  end
  if (ALARM_RST_HOURS < 0 || ALARM_RST_HOURS > 23) begin : g_bad_rst_h
    $error("alarm_controller: ALARM_RST_HOURS must be 0..23");
  end
  if (ALARM_RST_MINUTES < 0 || ALARM_RST_MINUTES > 59) begin : g_bad_rst_m
    $error("alarm_controller: ALARM_RST_MINUTES must be 0..59");
  end

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  function automatic logic [5:0] inc_minute(input logic [5:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [4:0] inc_hour(input logic [4:0] h);
    return (h >= 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [23:0] pack_hm(input logic [4:0] h, input logic [5:0] m);
    return 24'(h) * 24'd10000 + 24'(m) * 24'd100;
  endfunction

  state_t          state, next;
  logic [4:0]      alarm_h;
  logic [5:0]      alarm_m;
  logic [23:0]     time_prev;
  logic [23:0]     target;
  logic            time_change;
  logic            match_edge;
  logic            ring_entry;
  logic [RW-1:0]   ring_cnt;
  logic [BW-1:0]   blink_cnt;

  assign timer_adjust_minutes = adjust_minutes & ~set_mode;
  assign timer_adjust_hours   = adjust_hours & ~set_mode;
  assign alarm_number         = pack_hm(alarm_h, alarm_m);
  assign display_number       = set_mode ? alarm_number : time_number;
  assign ringing              = (state == RINGING);

  // Alarm time register; adjusts accepted in every state while set_mode is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_h <= 5'(ALARM_RST_HOURS);
      alarm_m <= 6'(ALARM_RST_MINUTES);
    end else if (set_mode) begin
      if (adjust_minutes) alarm_m <= inc_minute(alarm_m);
      if (adjust_hours)   alarm_h <= inc_hour(alarm_h);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) time_prev <= '0;
    else     time_prev <= time_number;
  end

  assign time_change = (time_number != time_prev);
  assign match_edge  = (time_number == target) && time_change;
  assign ring_entry  = (next == RINGING) && (state != RINGING);

`ifdef ALARM_SNOOZE_EN
  // match_time is held as hours/minutes; seconds are always 00 at a match
  logic [4:0]  match_h, snooze_h;
  logic [5:0]  match_m, snooze_m;
  logic [6:0]  min_sum;
  logic [23:0] snooze_number;

  always_comb begin
    min_sum = {1'b0, match_m} + 7'(SNOOZE_MINUTES);
    if (min_sum >= 7'd60) begin
      snooze_m = 6'(min_sum - 7'd60);
      snooze_h = inc_hour(match_h);
    end else begin
      snooze_m = min_sum[5:0];
      snooze_h = match_h;
    end
  end

  assign snooze_number = pack_hm(snooze_h, snooze_m);
  assign target        = (state == SNOOZE) ? snooze_number : alarm_number;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_h <= '0;
      match_m <= '0;
    end else if (ring_entry) begin
      match_h <= (state == SNOOZE) ? snooze_h : alarm_h;
      match_m <= (state == SNOOZE) ? snooze_m : alarm_m;
    end
  end
`else
  assign target = alarm_number;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DISARMED;
    else     state <= next;
  end

  // Disable beats everything; dismiss beats ring timeout
  always_comb begin
    next = state;
    if (!alarm_en) begin
      next = DISARMED;
    end else begin
      case (state)
        DISARMED: next = ARMED;
        ARMED:    if (match_edge) next = RINGING;
        RINGING: begin
          if (dismiss) begin
`ifdef ALARM_SNOOZE_EN
            next = SNOOZE;
`else
            next = ARMED;
`endif
          end else if (ring_cnt == RING_LAST) begin
            next = ARMED;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (dismiss)         next = ARMED;
          else if (match_edge) next = RINGING;
        end
`endif
        default:  next = DISARMED;
      endcase
    end
  end

  // Ring duration and blink counters; led forced low whenever not ringing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_cnt  <= '0;
      blink_cnt <= '0;
      led       <= 1'b0;
    end else if (ring_entry) begin
      ring_cnt  <= '0;
      blink_cnt <= '0;
      led       <= 1'b1;
    end else if (state == RINGING && next == RINGING) begin
      if (time_change && ring_cnt != RING_LAST) ring_cnt <= ring_cnt + RW'(1);
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        led       <= ~led;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      blink_cnt <= '0;
      led       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: stimulus pushes expectations, a negedge monitor compares them.
module tb_alarm_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] time_number;
  logic        alarm_en, set_mode, adjust_minutes, adjust_hours, dismiss;
  logic        timer_adjust_minutes, timer_adjust_hours;
  logic [23:0] alarm_number, display_number;
  logic        ringing, led;

  int checks = 0;
  int errors = 0;

  localparam int S_ALARM = 0, S_DISP = 1, S_RING = 2, S_LED = 3, S_TAM = 4, S_TAH = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [23:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [23:0] act;

  alarm_controller #(
    .CLK_FREQ(8), .BLINK_HZ(1), .RING_SECONDS(4), .SNOOZE_MINUTES(5),
    .ALARM_RST_HOURS(7), .ALARM_RST_MINUTES(0)
  ) dut (
    .clk(clk), .rst(rst), .time_number(time_number), .alarm_en(alarm_en),
    .set_mode(set_mode), .adjust_minutes(adjust_minutes), .adjust_hours(adjust_hours),
    .dismiss(dismiss), .timer_adjust_minutes(timer_adjust_minutes),
    .timer_adjust_hours(timer_adjust_hours), .alarm_number(alarm_number),
    .display_number(display_number), .ringing(ringing), .led(led)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pick(input int sel);
    case (sel)
      S_ALARM: return alarm_number;
      S_DISP:  return display_number;
      S_RING:  return 24'(ringing);
      S_LED:   return 24'(led);
      S_TAM:   return 24'(timer_adjust_minutes);
      default: return 24'(timer_adjust_hours);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      act = pick(cur.sel);
      checks++;
      if (act !== cur.val) begin
        errors++;
        $display("FAIL %s: got %0d required %0d at %0t", cur.name, act, cur.val, $time);
      end
    end
  end

  task automatic want(input string name, input int sel, input logic [23:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit hours, input int n, input logic [0:0] exp_timer);
    for (int i = 0; i < n; i++) begin
      if (hours) begin
        adjust_hours = 1'b1;
        want("timer_adj_h", S_TAH, 24'(exp_timer));
      end else begin
        adjust_minutes = 1'b1;
        want("timer_adj_m", S_TAM, 24'(exp_timer));
      end
      tick();
      adjust_hours   = 1'b0;
      adjust_minutes = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; time_number = 24'd12345; alarm_en = 1'b0; set_mode = 1'b0;
    adjust_minutes = 1'b0; adjust_hours = 1'b0; dismiss = 1'b0;

    // Reset values
    tick(); tick();
    want("rst_alarm", S_ALARM, 24'd70000);
    want("rst_ring",  S_RING,  24'd0);
    want("rst_led",   S_LED,   24'd0);
    want("rst_disp",  S_DISP,  24'd12345);
    checks++;
    if (alarm_number !== 24'd70000) begin
      errors++;
      $display("FAIL rst_alarm_direct: got %0d required 70000 at %0t", alarm_number, $time);
    end
    tick();
    rst = 1'b0;
    time_number = 24'd123456;
    want("disp_time", S_DISP, 24'd123456);
    tick();

    // Alarm adjust: 07:00 + 3 min, +17 h -> 00:03
    set_mode = 1'b1;
    pulse(1'b0, 3, 1'b0);
    pulse(1'b1, 17, 1'b0);
    want("alarm_set", S_ALARM, 24'd300);
    want("disp_alarm", S_DISP, 24'd300);
    checks++;
    if (alarm_number !== 24'd300) begin
      errors++;
      $display("FAIL alarm_set_direct: got %0d required 300 at %0t", alarm_number, $time);
    end
    tick();
    set_mode = 1'b0;
    adjust_minutes = 1'b1;
    want("pass_min", S_TAM, 24'd1);
    want("disp_back", S_DISP, 24'd123456);
    tick();
    adjust_minutes = 1'b0;
    adjust_hours = 1'b1;
    want("pass_hour", S_TAH, 24'd1);
    want("pass_min_lo", S_TAM, 24'd0);
    tick();
    adjust_hours = 1'b0;
    want("alarm_untouched", S_ALARM, 24'd300);
    set_mode = 1'b1;
    pulse(1'b1, 7, 1'b0);
    pulse(1'b0, 57, 1'b0);
    set_mode = 1'b0;
    want("alarm_0700", S_ALARM, 24'd70000);
    tick();

    // Ring, blink and timeout
    time_number = 24'd65958; alarm_en = 1'b1;
    tick(); tick();
    time_number = 24'd65959;
    tick();
    time_number = 24'd70000;
    want("ring_not_yet", S_RING, 24'd0);
    tick();
    want("ring_rise", S_RING, 24'd1);
    want("led_rise",  S_LED,  24'd1);
    checks++;
    if (ringing !== 1'b1) begin
      errors++;
      $display("FAIL ring_rise_direct: got %0d required 1 at %0t", ringing, $time);
    end
    tick(); tick(); tick();
    want("led_hold", S_LED, 24'd1);
    tick();
    want("led_toggle0", S_LED, 24'd0);
    tick(); tick(); tick();
    want("led_low_hold", S_LED, 24'd0);
    tick();
    want("led_toggle1", S_LED, 24'd1);
    for (int i = 1; i <= 3; i++) begin
      time_number = 24'(70000 + i);
      tick();
    end
    want("ring_before_timeout", S_RING, 24'd1);
    time_number = 24'd70004;
    tick(); tick();
    want("ring_timeout", S_RING, 24'd0);
    want("led_timeout",  S_LED,  24'd0);
    checks++;
    if (ringing !== 1'b0) begin
      errors++;
      $display("FAIL ring_timeout_direct: got %0d required 0 at %0t", ringing, $time);
    end
    time_number = 24'd70000;
    tick();
    want("rearmed_ring", S_RING, 24'd1);
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    want("dismiss_ring", S_RING, 24'd0);
    want("dismiss_led",  S_LED,  24'd0);
    tick();

    // Enable while the time already equals the alarm
    alarm_en = 1'b0;
    tick();
    alarm_en = 1'b1;
    tick(); tick(); tick();
    want("enable_on_match", S_RING, 24'd0);
    tick();

    // Snooze across midnight: alarm 23:58, +5 min -> 00:03:00
    set_mode = 1'b1;
    pulse(1'b1, 16, 1'b0);
    pulse(1'b0, 58, 1'b0);
    set_mode = 1'b0;
    want("alarm_2358", S_ALARM, 24'd235800);
    time_number = 24'd235759;
    tick();
    time_number = 24'd235800;
    tick();
    want("ring_2358", S_RING, 24'd1);
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    want("snooze_dismiss", S_RING, 24'd0);
    time_number = 24'd235900;
    tick();
    time_number = 24'd0;
    tick();
    want("no_ring_midnight", S_RING, 24'd0);
    time_number = 24'd300;
    tick();
`ifdef ALARM_SNOOZE_EN
    want("snooze_rering", S_RING, 24'd1);
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
`else
    want("no_snooze_rering", S_RING, 24'd0);
    tick();
`endif

    // Match edge coincident with alarm adjust, then disable priority over dismiss
    alarm_en = 1'b0;
    tick();
    alarm_en = 1'b1;
    tick();
    time_number = 24'd235759;
    tick();
    set_mode = 1'b1; adjust_minutes = 1'b1;
    time_number = 24'd235800;
    tick();
    set_mode = 1'b0; adjust_minutes = 1'b0;
    want("match_pre_adjust", S_RING, 24'd1);
    want("alarm_2359", S_ALARM, 24'd235900);
    alarm_en = 1'b0; dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    want("disable_ring", S_RING, 24'd0);
    want("disable_led",  S_LED,  24'd0);
    time_number = 24'd235859;
    tick();
    time_number = 24'd235900;
    tick();
    want("disarmed_no_ring", S_RING, 24'd0);

    // Asynchronous reset mid-ring
    alarm_en = 1'b1;
    tick();
    time_number = 24'd235859;
    tick();
    time_number = 24'd235900;
    tick();
    want("ring_before_rst", S_RING, 24'd1);
    tick();
    rst = 1'b1;
    want("async_rst_ring",  S_RING,  24'd0);
    want("async_rst_led",   S_LED,   24'd0);
    want("async_rst_alarm", S_ALARM, 24'd70000);
    tick();
    rst = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
